imm_gen_stage: RTL

//  Pipelined, XLEN-parametrised immediate generator for the pipelined core's decode stage.
//  - Accepts a 32-bit instruction plus a sideband tag over a valid/ready handshake.
//  - Produces the sign- or zero-extended immediate, its format class and an illegal-opcode flag.
//  - Registered output with a 2-entry skid buffer: full throughput, no combinational ready path.
//  - Sits between fetch/IF-ID register and the register-read/execute stage; supports flush on redirect.

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/imm_decode.sv | 77 +++++++
 rtl/imm_gen_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// Module : rv_pkg
// Brief  : Shared RV32/RV64 decode constants, immediate class and skid state.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
//------------------------------------------------------------------------------
// Module : imm_decode
// Brief  : Combinational instruction -> {immediate, format class, illegal}.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_decode
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_illegal
);

  logic [6:0]  w_opcode;
  logic [31:0] w_imm32;
  imm_type_e   w_type;
  logic        w_illegal;

  assign w_opcode = i_instr[6:0];

  // Every format fits in 32 bits; Z has bit 31 clear so the final
  // sign extension to XLEN doubles as its zero extension.
  always_comb begin
    w_imm32   = '0;
    w_type    = IMM_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        w_type  = IMM_I;
      end
      OPC_STORE: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        w_type  = IMM_S;
      end
      OPC_BRANCH: begin
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
        w_type  = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_imm32 = {i_instr[31:12], 12'b0};
        w_type  = IMM_U;
      end
      OPC_JAL: begin
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
        w_type  = IMM_J;
      end
      OPC_SYSTEM: begin
        if (CSR_EN && i_instr[14]) begin
          w_imm32 = {27'b0, i_instr[19:15]};
          w_type  = IMM_Z;
        end
      end
      OPC_OP, OPC_MISC_MEM: begin
        w_imm32 = '0;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign o_imm      = XLEN'($signed(w_imm32));
  assign o_imm_type = w_type;
  assign o_illegal  = w_illegal;

endmodule

`default_nettype wire

// File: rtl/imm_gen_stage.sv
//------------------------------------------------------------------------------
// Module : imm_gen_stage
// Brief  : Decode-stage immediate generator with registered output + skid slot.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_gen_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_imm_type,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "imm_gen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  logic [XLEN-1:0]  w_dec_imm;
  logic [2:0]       w_dec_type;
  logic             w_dec_illegal;

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  logic [XLEN-1:0]  r_main_imm;
  logic [2:0]       r_main_type;
  logic             r_main_illegal;
  logic [TAG_W-1:0] r_main_tag;
  logic [XLEN-1:0]  r_skid_imm;
  logic [2:0]       r_skid_type;
  logic             r_skid_illegal;
  logic [TAG_W-1:0] r_skid_tag;

  imm_decode #(
    .XLEN   (XLEN),
    .CSR_EN (CSR_EN)
  ) u_imm_decode (
    .i_instr    (i_instr),
    .o_imm      (w_dec_imm),
    .o_imm_type (w_dec_type),
    .o_illegal  (w_dec_illegal)
  );

  // Handshake flags derive only from registered state, never from i_ready.
  assign o_ready = (r_state != SKID_TWO);
  assign o_valid = (r_state != SKID_EMPTY);
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      w_state_nxt = SKID_EMPTY;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_push) begin
            w_state_nxt = SKID_ONE;
            w_load_main = 1'b1;
          end
        end
        SKID_ONE: begin
          if (w_push && w_pop) begin
            w_load_main = 1'b1;
          end else if (w_push) begin
            w_state_nxt = SKID_TWO;
            w_load_skid = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (w_pop) begin
            w_state_nxt      = SKID_ONE;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = SKID_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_imm     <= '0;
      r_main_type    <= IMM_NONE;
      r_main_illegal <= 1'b0;
      r_main_tag     <= '0;
      r_skid_imm     <= '0;
      r_skid_type    <= IMM_NONE;
      r_skid_illegal <= 1'b0;
      r_skid_tag     <= '0;
    end else begin
      if (w_load_main) begin
        if (w_main_from_skid) begin
          r_main_imm     <= r_skid_imm;
          r_main_type    <= r_skid_type;
          r_main_illegal <= r_skid_illegal;
          r_main_tag     <= r_skid_tag;
        end else begin
          r_main_imm     <= w_dec_imm;
          r_main_type    <= w_dec_type;
          r_main_illegal <= w_dec_illegal;
          r_main_tag     <= i_tag;
        end
      end
      if (w_load_skid) begin
        r_skid_imm     <= w_dec_imm;
        r_skid_type    <= w_dec_type;
        r_skid_illegal <= w_dec_illegal;
        r_skid_tag     <= i_tag;
      end
    end
  end

  assign o_imm      = r_main_imm;
  assign o_imm_type = r_main_type;
  assign o_illegal  = r_main_illegal;
  assign o_tag      = r_main_tag;

endmodule

`default_nettype wire
